// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: default sizes and helpers.
package stream_demux_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CNT_W    = 8;

  // Saturation ceiling of the drop counter at its default width.
  localparam int DROP_SAT = (1 << DEF_CNT_W) - 1;

  // Select width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of the demultiplexer.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2_min1(CHANNELS)
) ();

  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;

  // Environment side: producer drives the input, consumers drive out_ready.
  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Load replaces the held word (even while it drains); a drain without load empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot state; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  // Slot can take a word this cycle if empty or being drained right now.
  assign free      = !valid_q | out_ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS stream demultiplexer with broadcast and drop counting.
// Note: out_ready reaches in_ready combinationally; in_valid never does.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2_min1(CHANNELS),
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  stream_demux_if.slave     bus,
  output logic [CNT_W-1:0]  drop_count,
  output logic              busy
);

  localparam int               SEL_SPAN = 1 << SEL_W;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] load;
  logic [SEL_SPAN-1:0] free_pad;
  logic                sel_ok;
  logic                all_free;
  logic                accept;
  logic [CNT_W-1:0]    drop_q, drop_d;

  assign sel_ok   = {1'b0, bus.in_sel} < CH_LIM;
  assign all_free = &free;
  assign accept   = bus.in_valid & bus.in_ready;

  // Widen free[] to the full select range so unused codes index safely.
  always_comb begin
    free_pad                 = '0;
    free_pad[CHANNELS-1:0]   = free;
  end

  // Input readiness: broadcast needs every slot, out-of-range words are sunk.
  always_comb begin
    bus.in_ready = 1'b0;
    if (enable) begin
      if (bus.in_bcast)  bus.in_ready = all_free;
      else if (!sel_ok)  bus.in_ready = 1'b1;
      else               bus.in_ready = free_pad[bus.in_sel];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
    assign load[i] = accept & (bus.in_bcast | (sel_ok & (bus.in_sel == SEL_W'(i))));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[i]),
      .out_valid (bus.out_valid[i]),
      .out_data  (bus.out_data[i*WIDTH +: WIDTH]),
      .free      (free[i])
    );
  end

  // Count accepted unicast words with no destination, saturating at the top.
  always_comb begin
    drop_d = drop_q;
    if (accept && !bus.in_bcast && !sel_ok && drop_q != CNT_SAT)
      drop_d = drop_q + 1'b1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;
  assign busy       = |bus.out_valid;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: vector table plus reset and saturation sequences.
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en4, en3;
  logic [7:0] drop4, drop3;
  logic busy4, busy3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(4), .CHANNELS(4)) if4 ();
  stream_demux_if #(.WIDTH(4), .CHANNELS(3)) if3 ();

  stream_demux #(.WIDTH(4), .CHANNELS(4), .CNT_W(8)) u4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en4),
    .bus        (if4.slave),
    .drop_count (drop4),
    .busy       (busy4)
  );

  stream_demux #(.WIDTH(4), .CHANNELS(3), .CNT_W(8)) u3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en3),
    .bus        (if3.slave),
    .drop_count (drop3),
    .busy       (busy3)
  );

  typedef struct packed {
    logic        en;
    logic [3:0]  data;
    logic [1:0]  sel;
    logic        bcast;
    logic        valid;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_rdy;
    int bad_vld;
    int exp_drop;

    //            en data  sel  bc   vld  ordy     rdy  valid    data
    vec[0]  = '{1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0000};
    vec[1]  = '{1'b1, 4'hA, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 16'h0A00};
    vec[2]  = '{1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0A00};
    vec[3]  = '{1'b1, 4'h3, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 16'h0A30};
    vec[4]  = '{1'b1, 4'h5, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 16'h0A30};
    vec[5]  = '{1'b1, 4'h5, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 16'h0A50};
    vec[6]  = '{1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0A50};
    vec[7]  = '{1'b1, 4'h7, 2'd3, 1'b0, 1'b1, 4'b0111, 1'b1, 4'b1000, 16'h7A50};
    vec[8]  = '{1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b1000, 16'h7A50};
    vec[9]  = '{1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 16'hFFFF};
    vec[10] = '{1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 4'b0101, 1'b0, 4'b1010, 16'hFFFF};
    vec[11] = '{1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 16'hFFFF};
    vec[12] = '{1'b1, 4'h2, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'hFFF2};
    vec[13] = '{1'b1, 4'h4, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'hFF42};
    vec[14] = '{1'b1, 4'h6, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1011, 16'h6F42};

    rst_n = 1'b0;
    en4 = 1'b1; en3 = 1'b0;
    if4.in_data = '0; if4.in_sel = '0; if4.in_bcast = 1'b0; if4.in_valid = 1'b0; if4.out_ready = '0;
    if3.in_data = '0; if3.in_sel = '0; if3.in_bcast = 1'b0; if3.in_valid = 1'b0; if3.out_ready = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(if4.out_valid), 32'h0);
    chk("rst_out_data",  32'(if4.out_data), 32'h0);
    chk("rst_drop",      32'(drop4), 32'h0);
    chk("rst_busy",      32'(busy4), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      en4           = vec[i].en;
      if4.in_data   = vec[i].data;
      if4.in_sel    = vec[i].sel;
      if4.in_bcast  = vec[i].bcast;
      if4.in_valid  = vec[i].valid;
      if4.out_ready = vec[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(if4.in_ready), 32'(vec[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(if4.out_valid), 32'(vec[i].exp_valid));
      chk($sformatf("v%0d_out_data", i),  32'(if4.out_data),  32'(vec[i].exp_data));
      chk($sformatf("v%0d_busy", i),      32'(busy4), 32'(vec[i].exp_valid != 4'b0000));
      chk($sformatf("v%0d_drop", i),      32'(drop4), 32'h0);
    end

    // Mid-stream reset with held words (out_valid=1011) while enable=0 drains channel 0.
    en4 = 1'b0;
    if4.in_valid  = 1'b0;
    if4.out_ready = 4'b0001;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(if4.out_valid), 32'h0);
    chk("mrst_out_data",  32'(if4.out_data), 32'h0);
    chk("mrst_busy",      32'(busy4), 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("mrst_post_valid", 32'(if4.out_valid), 32'h0);

    en4 = 1'b1;
    if4.in_data = 4'h9; if4.in_sel = 2'd0; if4.in_bcast = 1'b0; if4.in_valid = 1'b1;
    if4.out_ready = 4'b0000;
    #1;
    chk("post_load_ready", 32'(if4.in_ready), 32'h1);
    tick();
    chk("post_load_valid", 32'(if4.out_valid), 32'h1);
    chk("post_load_data",  32'(if4.out_data), 32'h0009);

    en4 = 1'b0;
    if4.in_data = 4'h8; if4.in_sel = 2'd1;
    #1;
    chk("dis_in_ready", 32'(if4.in_ready), 32'h0);
    tick();
    chk("dis_hold_valid", 32'(if4.out_valid), 32'h1);
    chk("dis_hold_data",  32'(if4.out_data), 32'h0009);

    if4.out_ready = 4'b0001;
    #1;
    chk("dis_drain_ready", 32'(if4.in_ready), 32'h0);
    tick();
    chk("dis_drain_valid", 32'(if4.out_valid), 32'h0);
    chk("dis_drain_data",  32'(if4.out_data), 32'h0009);
    if4.in_valid = 1'b0;

    // Three-channel instance: select 3 has no channel and must be sunk and counted.
    bad_rdy = 0;
    bad_vld = 0;
    en3 = 1'b1;
    if3.in_data = 4'hC; if3.in_sel = 2'd3; if3.in_bcast = 1'b0; if3.in_valid = 1'b1;
    if3.out_ready = 3'b111;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (if3.in_ready !== 1'b1) bad_rdy++;
      tick();
      if (if3.out_valid !== 3'b000) bad_vld++;
      exp_drop = (k + 1 > 255) ? 255 : k + 1;
      if (k == 9)   chk("c3_drop_10",  32'(drop3), 32'(exp_drop));
      if (k == 254) chk("c3_drop_255", 32'(drop3), 32'(exp_drop));
    end
    chk("c3_in_ready_all", 32'(bad_rdy), 32'h0);
    chk("c3_no_valid",     32'(bad_vld), 32'h0);
    chk("c3_drop_sat",     32'(drop3), 32'(DROP_SAT));
    chk("c3_busy",         32'(busy3), 32'h0);
    if3.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
